// File: rtl/lsu_arb_pkg.sv
// Shared types for the LSU port arbiter.
// Holds the sequencer state encoding and master id type.
package lsu_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    WAIT,
    RESP
  } state_e;

  typedef logic mid_t;

  localparam mid_t M0 = 1'b0;
  localparam mid_t M1 = 1'b1;

  localparam int LAT_W = 3;

  function automatic mid_t other_mid(input mid_t m);
    return ~m;
  endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-input round-robin selector.
// Pointer favours the master that did not win last time.
module rr_arbiter2
  import lsu_arb_pkg::*;
(
  input  logic       clk,
  input  logic       reset_n,
  input  logic [1:0] req,
  input  logic       update,
  output mid_t       winner,
  output logic       any_req
);

  mid_t ptr_q;

  // pick the sole requester, or the favoured one on a tie
  always_comb begin
    any_req = |req;
    winner  = M0;
    unique case (1'b1)
      (req == 2'b11): winner = ptr_q;
      (req == 2'b10): winner = M1;
      default:        winner = M0;
    endcase
  end

  // after a grant the loser becomes favoured
  always_ff @(posedge clk or posedge reset_n) begin
    if (reset_n) begin
      ptr_q <= M0;
    end else if (update && any_req) begin
      ptr_q <= other_mid(winner);
    end
  end

endmodule

// File: rtl/lsu_arbiter.sv
// Arbiter/sequencer in front of the LSU load/store port.
// One transaction at a time: grant, access, wait latency, respond.
module lsu_arbiter
  import lsu_arb_pkg::*;
#(
  parameter int RD_LATENCY = 1,
  parameter int ADDR_W     = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              m0_req,
  input  logic              m0_we,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [31:0]       m0_wdata,
  input  logic [2:0]        m0_funct3,
  output logic              m0_gnt,
  output logic              m0_rvalid,
  output logic [31:0]       m0_rdata,
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [31:0]       m1_wdata,
  input  logic [2:0]        m1_funct3,
  output logic              m1_gnt,
  output logic              m1_rvalid,
  output logic [31:0]       m1_rdata,
  output logic [ADDR_W-1:0] lsu_addr,
  output logic [31:0]       lsu_st_data,
  output logic              lsu_wren,
  output logic [2:0]        lsu_funct3,
  input  logic [31:0]       lsu_ld_data,
  output logic              busy
);

  if (RD_LATENCY < 1 || RD_LATENCY > 7) begin : g_bad_lat
    $error("lsu_arbiter: RD_LATENCY must be 1..7");
  end

  localparam logic [LAT_W-1:0] LAT_LOAD = LAT_W'(RD_LATENCY - 1);

  state_e            state_q, state_d;
  mid_t              id_q, id_d;
  logic              we_q, we_d;
  logic [LAT_W-1:0]  cnt_q, cnt_d;

  logic [ADDR_W-1:0] addr_d;
  logic [31:0]       st_d;
  logic [2:0]        f3_d;
  logic              wren_d;
  logic              gnt0_d, gnt1_d;
  logic              rv0_d, rv1_d;
  logic [31:0]       rd0_d, rd1_d;
  logic              busy_d;

  mid_t              winner;
  logic              any_req;
  logic              upd;

  logic              sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [31:0]       sel_wdata;
  logic [2:0]        sel_f3;

  rr_arbiter2 u_rr (
    .clk     (clk),
    .reset_n (reset_n),
    .req     ({m1_req, m0_req}),
    .update  (upd),
    .winner  (winner),
    .any_req (any_req)
  );

  // winner payload mux
  always_comb begin
    sel_we    = m0_we;
    sel_addr  = m0_addr;
    sel_wdata = m0_wdata;
    sel_f3    = m0_funct3;
    if (winner == M1) begin
      sel_we    = m1_we;
      sel_addr  = m1_addr;
      sel_wdata = m1_wdata;
      sel_f3    = m1_funct3;
    end
  end

  // next-state and next-output logic
  always_comb begin
    state_d = state_q;
    id_d    = id_q;
    we_d    = we_q;
    cnt_d   = cnt_q;
    addr_d  = lsu_addr;
    st_d    = lsu_st_data;
    f3_d    = lsu_funct3;
    wren_d  = 1'b0;
    gnt0_d  = 1'b0;
    gnt1_d  = 1'b0;
    rv0_d   = 1'b0;
    rv1_d   = 1'b0;
    rd0_d   = m0_rdata;
    rd1_d   = m1_rdata;
    upd     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (any_req) begin
          upd     = 1'b1;
          id_d    = winner;
          we_d    = sel_we;
          addr_d  = sel_addr;
          st_d    = sel_wdata;
          f3_d    = sel_f3;
          wren_d  = sel_we;
          gnt0_d  = (winner == M0);
          gnt1_d  = (winner == M1);
          state_d = ACCESS;
        end
      end
      ACCESS: begin
        cnt_d   = LAT_LOAD;
        state_d = WAIT;
      end
      WAIT: begin
        if (cnt_q == '0) begin
          state_d = RESP;
          if (id_q == M0) begin
            rv0_d = 1'b1;
            rd0_d = we_q ? 32'h0 : lsu_ld_data;
          end else begin
            rv1_d = 1'b1;
            rd1_d = we_q ? 32'h0 : lsu_ld_data;
          end
        end else begin
          cnt_d = cnt_q - LAT_W'(1);
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  // state and registered outputs
  always_ff @(posedge clk or posedge reset_n) begin
    if (reset_n) begin
      state_q     <= IDLE;
      id_q        <= M0;
      we_q        <= 1'b0;
      cnt_q       <= '0;
      lsu_addr    <= '0;
      lsu_st_data <= '0;
      lsu_funct3  <= '0;
      lsu_wren    <= 1'b0;
      m0_gnt      <= 1'b0;
      m1_gnt      <= 1'b0;
      m0_rvalid   <= 1'b0;
      m1_rvalid   <= 1'b0;
      m0_rdata    <= '0;
      m1_rdata    <= '0;
      busy        <= 1'b0;
    end else begin
      state_q     <= state_d;
      id_q        <= id_d;
      we_q        <= we_d;
      cnt_q       <= cnt_d;
      lsu_addr    <= addr_d;
      lsu_st_data <= st_d;
      lsu_funct3  <= f3_d;
      lsu_wren    <= wren_d;
      m0_gnt      <= gnt0_d;
      m1_gnt      <= gnt1_d;
      m0_rvalid   <= rv0_d;
      m1_rvalid   <= rv1_d;
      m0_rdata    <= rd0_d;
      m1_rdata    <= rd1_d;
      busy        <= busy_d;
    end
  end

endmodule

// File: tb/tb_lsu_arbiter.sv
// Randomized scoreboard bench for lsu_arbiter.
// Two instances (RD_LATENCY 1 and 3) run side by side.
module tb_lsu_arbiter;

  localparam int AW = 16;

  int vectors = 0;
  int miscompares = 0;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int              cyc;
    logic            m;
    logic            we;
    logic [AW-1:0]   addr;
    logic [31:0]     wd;
    logic [2:0]      f3;
  } gnt_t;

  typedef struct {
    int          cyc;
    logic [31:0] d;
  } rsp_t;

  task automatic chk(input int g, input int c, input string nm,
                     input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s inst%0d cyc%0d: got %0h want %0h",
               nm, g, c, act, exp);
    end
  endtask

  for (genvar g = 0; g < 2; g++) begin : inst
    localparam int RD = (g == 0) ? 1 : 3;

    logic              reset_n;
    logic              req   [2];
    logic              we    [2];
    logic [AW-1:0]     addr  [2];
    logic [31:0]       wd    [2];
    logic [2:0]        f3    [2];
    logic              gnt   [2];
    logic              rv    [2];
    logic [31:0]       rd    [2];
    logic [AW-1:0]     lsu_addr;
    logic [31:0]       lsu_st_data;
    logic              lsu_wren;
    logic [2:0]        lsu_funct3;
    logic [31:0]       lsu_ld_data;
    logic              busy;
    logic              fin = 1'b0;

    int                cyc;
    logic [31:0]       ld_hist [4096];
    gnt_t              gq [$];
    rsp_t              rq [2][$];
    int                free_at;
    int                blo;
    int                bhi;
    logic              ptr;
    logic [31:0]       last [2];

    lsu_arbiter #(.RD_LATENCY(RD), .ADDR_W(AW)) dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .m0_req      (req[0]),
      .m0_we       (we[0]),
      .m0_addr     (addr[0]),
      .m0_wdata    (wd[0]),
      .m0_funct3   (f3[0]),
      .m0_gnt      (gnt[0]),
      .m0_rvalid   (rv[0]),
      .m0_rdata    (rd[0]),
      .m1_req      (req[1]),
      .m1_we       (we[1]),
      .m1_addr     (addr[1]),
      .m1_wdata    (wd[1]),
      .m1_funct3   (f3[1]),
      .m1_gnt      (gnt[1]),
      .m1_rvalid   (rv[1]),
      .m1_rdata    (rd[1]),
      .lsu_addr    (lsu_addr),
      .lsu_st_data (lsu_st_data),
      .lsu_wren    (lsu_wren),
      .lsu_funct3  (lsu_funct3),
      .lsu_ld_data (lsu_ld_data),
      .busy        (busy)
    );

    // reference model: decides grants from request levels at each edge
    initial begin
      cyc     = 0;
      ptr     = 1'b0;
      free_at = 0;
      blo     = 0;
      bhi     = -1;
      forever begin
        @(posedge clk);
        cyc++;
        if (reset_n) begin
          free_at = cyc + 1;
          ptr     = 1'b0;
          bhi     = -1;
        end else if (cyc >= free_at && (req[0] || req[1])) begin
          gnt_t gt;
          rsp_t rs;
          logic w;
          w = (req[0] && req[1]) ? ptr : req[1];
          ptr = ~w;
          gt.cyc  = cyc;
          gt.m    = w;
          gt.we   = we[w];
          gt.addr = addr[w];
          gt.wd   = wd[w];
          gt.f3   = f3[w];
          gq.push_back(gt);
          rs.cyc = cyc + 1 + RD;
          rs.d   = we[w] ? 32'h0 : ld_hist[(cyc + RD) % 4096];
          rq[w].push_back(rs);
          free_at = cyc + RD + 3;
          blo     = cyc;
          bhi     = cyc + RD + 1;
        end
      end
    end

    // monitor: compares every cycle against the queued expectations
    initial begin
      last[0] = '0;
      last[1] = '0;
      forever begin
        @(negedge clk);
        if (reset_n) begin
          gq.delete();
          rq[0].delete();
          rq[1].delete();
          last[0] = '0;
          last[1] = '0;
          chk(g, cyc, "reset_ctl",
              {gnt[0], gnt[1], rv[0], rv[1], lsu_wren, busy,
               lsu_funct3, lsu_addr}, '0);
          chk(g, cyc, "reset_rdata", {rd[0], rd[1]}, '0);
          chk(g, cyc, "reset_st", lsu_st_data, '0);
        end else begin
          logic eg;
          eg = (gq.size() > 0) && (gq[0].cyc == cyc);
          for (int m = 0; m < 2; m++) begin
            chk(g, cyc, m ? "m1_gnt" : "m0_gnt", gnt[m],
                eg && (gq[0].m == m[0]));
          end
          if (eg) begin
            chk(g, cyc, "wren", lsu_wren, gq[0].we);
            chk(g, cyc, "addr", lsu_addr, gq[0].addr);
            chk(g, cyc, "st_data", lsu_st_data, gq[0].wd);
            chk(g, cyc, "funct3", lsu_funct3, gq[0].f3);
            void'(gq.pop_front());
          end else begin
            chk(g, cyc, "wren_idle", lsu_wren, 1'b0);
          end
          for (int m = 0; m < 2; m++) begin
            logic er;
            er = (rq[m].size() > 0) && (rq[m][0].cyc == cyc);
            chk(g, cyc, m ? "m1_rvalid" : "m0_rvalid", rv[m], er);
            if (er) begin
              chk(g, cyc, m ? "m1_rdata" : "m0_rdata", rd[m], rq[m][0].d);
              last[m] = rq[m][0].d;
              void'(rq[m].pop_front());
            end else begin
              chk(g, cyc, m ? "m1_rdata_hold" : "m0_rdata_hold",
                  rd[m], last[m]);
            end
          end
          chk(g, cyc, "busy", busy, (cyc >= blo) && (cyc <= bhi));
        end
      end
    end

    task automatic payload(input int m);
      we[m]   = 1'($urandom_range(0, 1));
      addr[m] = AW'($urandom);
      wd[m]   = $urandom;
      f3[m]   = 3'($urandom_range(0, 7));
    endtask

    task automatic step(input int keep, input int raise, input int wdraw);
      @(posedge clk);
      #2;
      lsu_ld_data = ld_hist[cyc % 4096];
      for (int m = 0; m < 2; m++) begin
        if (gnt[m]) begin
          if ($urandom_range(0, 99) < keep) payload(m);
          else req[m] = 1'b0;
        end else if (req[m]) begin
          if ($urandom_range(0, 99) < wdraw) req[m] = 1'b0;
        end else if ($urandom_range(0, 99) < raise) begin
          req[m] = 1'b1;
          payload(m);
        end
      end
    endtask

    // stimulus
    initial begin
      int rst_left;
      rst_left = 0;
      reset_n = 1'b1;
      for (int i = 0; i < 4096; i++) ld_hist[i] = $urandom;
      for (int m = 0; m < 2; m++) begin
        req[m] = 1'b0;
        we[m] = 1'b0;
        addr[m] = '0;
        wd[m] = '0;
        f3[m] = '0;
      end
      lsu_ld_data = '0;
      repeat (3) @(posedge clk);
      #2;
      reset_n = 1'b0;
      req[0]  = 1'b1;
      we[0]   = 1'b0;
      addr[0] = 16'h0010;
      wd[0]   = 32'h0;
      f3[0]   = 3'b010;
      req[1]  = 1'b1;
      we[1]   = 1'b1;
      addr[1] = 16'h0004;
      wd[1]   = 32'h12345678;
      f3[1]   = 3'b010;
      for (int i = 0; i < 60; i++) step(100, 100, 0);
      for (int i = 0; i < 1200; i++) begin
        step(30, 20, 4);
        if (rst_left > 0) begin
          rst_left--;
          if (rst_left == 0) reset_n = 1'b0;
        end else if ($urandom_range(0, 149) == 0) begin
          reset_n  = 1'b1;
          rst_left = $urandom_range(1, 2);
        end
      end
      reset_n = 1'b0;
      for (int i = 0; i < 20; i++) step(0, 0, 100);
      chk(g, cyc, "drain",
          gq.size() + rq[0].size() + rq[1].size(), 0);
      fin = 1'b1;
    end
  end

  initial begin
    wait (inst[0].fin && inst[1].fin);
    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1);
  end

endmodule
